// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings, state codes and instruction decoder for multicycle_ctrl
package ctrl_pkg;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;

  localparam logic [3:0] EXT_NOP = 4'b0000;
  localparam logic [3:0] EXT_AND = 4'b0001;
  localparam logic [3:0] EXT_OR  = 4'b0010;
  localparam logic [3:0] EXT_XOR = 4'b0011;
  localparam logic [3:0] EXT_ADD = 4'b0101;
  localparam logic [3:0] EXT_SUB = 4'b1001;
  localparam logic [3:0] EXT_CMP = 4'b1011;
  localparam logic [3:0] EXT_MOV = 4'b1101;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STORE = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_GE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;

  localparam logic [4:0] ALU_NOP   = 5'd0;
  localparam logic [4:0] ALU_ADD   = 5'd1;
  localparam logic [4:0] ALU_SUB   = 5'd2;
  localparam logic [4:0] ALU_AND   = 5'd3;
  localparam logic [4:0] ALU_OR    = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_PASSB = 5'd6;

  localparam int PSR_N = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_C = 0;

  typedef enum logic [3:0] {
    K_NOP, K_ILLEGAL, K_ALU, K_CMP, K_BRANCH, K_JCOND, K_JAL, K_LOAD, K_STORE
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [4:0] alu_op;
    logic       use_imm;
    logic       sext_imm;
    logic       set_psr;
  } dec_t;

  // Only the arithmetic forms update the PSR; logic ops and moves leave it alone.
  function automatic dec_t decode(input logic [15:0] instr);
    dec_t d;
    d.kind     = K_ILLEGAL;
    d.alu_op   = ALU_NOP;
    d.use_imm  = 1'b0;
    d.sext_imm = 1'b1;
    d.set_psr  = 1'b0;
    case (instr[15:12])
      OP_RTYPE: begin
        d.kind = K_ALU;
        case (instr[7:4])
          EXT_NOP: d.kind = K_NOP;
          EXT_ADD: begin d.alu_op = ALU_ADD; d.set_psr = 1'b1; end
          EXT_SUB: begin d.alu_op = ALU_SUB; d.set_psr = 1'b1; end
          EXT_CMP: begin d.kind = K_CMP; d.alu_op = ALU_SUB; d.set_psr = 1'b1; end
          EXT_AND: d.alu_op = ALU_AND;
          EXT_OR:  d.alu_op = ALU_OR;
          EXT_XOR: d.alu_op = ALU_XOR;
          EXT_MOV: d.alu_op = ALU_PASSB;
          default: d.kind = K_ILLEGAL;
        endcase
      end
      OP_ADDI: begin
        d.kind = K_ALU; d.alu_op = ALU_ADD; d.use_imm = 1'b1; d.set_psr = 1'b1;
      end
      OP_SUBI: begin
        d.kind = K_ALU; d.alu_op = ALU_SUB; d.use_imm = 1'b1; d.set_psr = 1'b1;
      end
      OP_CMPI: begin
        d.kind = K_CMP; d.alu_op = ALU_SUB; d.use_imm = 1'b1; d.set_psr = 1'b1;
      end
      OP_MOVI: begin
        d.kind = K_ALU; d.alu_op = ALU_PASSB; d.use_imm = 1'b1; d.sext_imm = 1'b0;
      end
      OP_MEM: begin
        case (instr[7:4])
          EXT_LOAD:  d.kind = K_LOAD;
          EXT_STORE: d.kind = K_STORE;
          EXT_JAL:   d.kind = K_JAL;
          EXT_JCOND: d.kind = K_JCOND;
          default:   d.kind = K_ILLEGAL;
        endcase
      end
      OP_BCOND: d.kind = K_BRANCH;
      default: d.kind = K_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - branch/jump condition evaluation against the latched PSR
module cond_eval (
  input  logic [3:0] cond,
  input  logic [2:0] psr,
  output logic       taken
);
  import ctrl_pkg::*;

  always_comb begin
    case (cond)
      COND_EQ: taken = psr[PSR_Z];
      COND_NE: taken = !psr[PSR_Z];
      COND_CS: taken = psr[PSR_C];
      COND_CC: taken = !psr[PSR_C];
      COND_LT: taken = psr[PSR_N];
      COND_GE: taken = !psr[PSR_N];
      COND_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle CPU control unit: FSM, decode, PSR and datapath steering
module multicycle_ctrl #(
  parameter int DATA_W  = 16,
  parameter int IMEM_AW = 9,
  parameter int DMEM_AW = 9,
  parameter int RF_AW   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               step,
  input  logic [DATA_W-1:0]  pc_in,
  output logic               pc_en,
  output logic [DATA_W-1:0]  pc_next,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [15:0]        imem_dout,
  output logic               dmem_en,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_din,
  input  logic [DATA_W-1:0]  dmem_dout,
  output logic               rf_we,
  output logic [RF_AW-1:0]   rf_waddr,
  output logic [RF_AW-1:0]   rf_ra_addr,
  output logic [RF_AW-1:0]   rf_rb_addr,
  output logic [DATA_W-1:0]  rf_wdata,
  input  logic [DATA_W-1:0]  rf_ra_data,
  input  logic [DATA_W-1:0]  rf_rb_data,
  output logic [4:0]         alu_op,
  output logic               alu_src_imm,
  output logic [DATA_W-1:0]  alu_imm,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic [2:0]         alu_flags_in,
  output logic [2:0]         psr_out,
  output logic [15:0]        ir_out,
  output logic               illegal_op,
  output logic [2:0]         state_out
);
  import ctrl_pkg::*;

  logic [2:0]        state, state_nx;
  logic [15:0]       ir;
  logic [2:0]        psr;
  logic [15:0]       instr;
  dec_t              dec;
  logic              taken;
  logic [DATA_W-1:0] pc_inc, br_target, imm_sext;
  logic              unused_rb;

  // In DECODE the instruction is still on the BRAM output; later states use the latched copy.
  assign instr = (state == S_DECODE) ? imem_dout : ir;
  assign dec   = decode(instr);

  assign imm_sext    = {{(DATA_W-8){instr[7]}}, instr[7:0]};
  assign alu_imm     = dec.sext_imm ? imm_sext : DATA_W'(instr[7:0]);
  assign pc_inc      = pc_in + DATA_W'(1);
  assign br_target   = pc_in + imm_sext;
  assign rf_ra_addr  = RF_AW'(instr[3:0]);
  assign rf_rb_addr  = RF_AW'(instr[11:8]);
  assign imem_addr   = pc_in[IMEM_AW-1:0];
  assign ir_out      = ir;
  assign psr_out     = psr;
  assign state_out   = state;
  assign unused_rb   = ^rf_rb_data;

  cond_eval u_cond_eval (
    .cond  (instr[11:8]),
    .psr   (psr),
    .taken (taken)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
      ir    <= '0;
      psr   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) ir <= imem_dout;
      if (state == S_EXEC && dec.set_psr) psr <= alu_flags_in;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (run || step) state_nx = S_DECODE;
      S_DECODE: state_nx = (dec.kind == K_NOP || dec.kind == K_ILLEGAL) ? S_FETCH : S_EXEC;
      S_EXEC: begin
        case (dec.kind)
          K_ALU:            state_nx = S_WB;
          K_LOAD, K_STORE:  state_nx = S_MEM;
          default:          state_nx = S_FETCH;
        endcase
      end
      S_MEM:    state_nx = (dec.kind == K_LOAD) ? S_WB : S_FETCH;
      S_WB:     state_nx = S_FETCH;
      default:  state_nx = S_FETCH;
    endcase
  end

  // Everything is suppressed while reset is held so an aborted instruction leaves no trace.
  always_comb begin
    pc_en       = 1'b0;
    pc_next     = pc_in;
    imem_en     = 1'b1;
    dmem_en     = 1'b0;
    dmem_we     = 1'b0;
    dmem_addr   = rf_ra_data[DMEM_AW-1:0];
    dmem_din    = rf_ra_data;
    rf_we       = 1'b0;
    rf_waddr    = RF_AW'(instr[11:8]);
    rf_wdata    = alu_out;
    alu_op      = ALU_NOP;
    alu_src_imm = 1'b0;
    illegal_op  = 1'b0;
    if (rst_n) begin
      case (state)
        S_DECODE: begin
          if (dec.kind == K_NOP || dec.kind == K_ILLEGAL) begin
            pc_en      = 1'b1;
            pc_next    = pc_inc;
            illegal_op = (dec.kind == K_ILLEGAL);
          end
        end
        S_EXEC: begin
          case (dec.kind)
            K_ALU: begin
              alu_op      = dec.alu_op;
              alu_src_imm = dec.use_imm;
            end
            K_CMP: begin
              alu_op      = dec.alu_op;
              alu_src_imm = dec.use_imm;
              pc_en       = 1'b1;
              pc_next     = pc_inc;
            end
            K_BRANCH: begin
              pc_en   = 1'b1;
              pc_next = taken ? br_target : pc_inc;
            end
            K_JCOND: begin
              pc_en   = 1'b1;
              pc_next = taken ? rf_ra_data : pc_inc;
            end
            K_JAL: begin
              // rs is read combinationally this cycle, so rd==rs still jumps to the old value.
              rf_we    = 1'b1;
              rf_wdata = pc_inc;
              pc_en    = 1'b1;
              pc_next  = rf_ra_data;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          dmem_en = 1'b1;
          if (dec.kind == K_STORE) begin
            dmem_we   = 1'b1;
            dmem_addr = rf_rb_data[DMEM_AW-1:0];
            pc_en     = 1'b1;
            pc_next   = pc_inc;
          end
        end
        S_WB: begin
          rf_we   = 1'b1;
          pc_en   = 1'b1;
          pc_next = pc_inc;
          if (dec.kind == K_LOAD) begin
            rf_wdata = dmem_dout;
          end else begin
            alu_op      = dec.alu_op;
            alu_src_imm = dec.use_imm;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl with PC, BRAM, RF and ALU models
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int DW = 16;
  localparam int EV_ILL = 0;
  localparam int EV_RF  = 1;
  localparam int EV_DM  = 2;
  localparam int EV_PC  = 3;

  logic clk = 1'b0;
  logic rst_n, run, step;
  logic [DW-1:0] pc_in, pc_next, dmem_din, dmem_dout, rf_wdata, rf_ra_data, rf_rb_data;
  logic [DW-1:0] alu_imm, alu_out;
  logic pc_en, imem_en, dmem_en, dmem_we, rf_we, alu_src_imm, illegal_op;
  logic [8:0] imem_addr, dmem_addr;
  logic [15:0] imem_dout, ir_out;
  logic [3:0] rf_waddr, rf_ra_addr, rf_rb_addr;
  logic [4:0] alu_op;
  logic [2:0] alu_flags_in, psr_out, state_out;

  always #5 clk = ~clk;

  multicycle_ctrl #(.DATA_W(DW), .IMEM_AW(9), .DMEM_AW(9), .RF_AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .pc_in(pc_in), .pc_en(pc_en),
    .pc_next(pc_next), .imem_en(imem_en), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_din(dmem_din),
    .dmem_dout(dmem_dout), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_ra_addr(rf_ra_addr),
    .rf_rb_addr(rf_rb_addr), .rf_wdata(rf_wdata), .rf_ra_data(rf_ra_data),
    .rf_rb_data(rf_rb_data), .alu_op(alu_op), .alu_src_imm(alu_src_imm), .alu_imm(alu_imm),
    .alu_out(alu_out), .alu_flags_in(alu_flags_in), .psr_out(psr_out), .ir_out(ir_out),
    .illegal_op(illegal_op), .state_out(state_out)
  );

  // Datapath models: PC register, sync-read BRAMs, async-read register file, ALU
  logic [15:0]   imem [0:511];
  logic [DW-1:0] dmem [0:511];
  logic [DW-1:0] rf   [0:15];
  logic [DW-1:0] pc;
  logic          pc_set;
  logic [DW-1:0] pc_set_val;

  always @(posedge clk) begin
    if (pc_set) pc <= pc_set_val;
    else if (pc_en) pc <= pc_next;
    if (imem_en) imem_dout <= imem[imem_addr];
    if (dmem_en) begin
      if (dmem_we) dmem[dmem_addr] <= dmem_din;
      dmem_dout <= dmem[dmem_addr];
    end
    if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  assign pc_in      = pc;
  assign rf_ra_data = rf[rf_ra_addr];
  assign rf_rb_data = rf[rf_rb_addr];

  logic [DW-1:0] alu_a, alu_b;
  logic [DW:0]   alu_wide;
  always_comb begin
    alu_a    = rf_rb_data;
    alu_b    = alu_src_imm ? alu_imm : rf_ra_data;
    alu_wide = '0;
    case (alu_op)
      ALU_ADD:   alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_SUB:   alu_wide = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
      ALU_AND:   alu_wide = {1'b0, alu_a & alu_b};
      ALU_OR:    alu_wide = {1'b0, alu_a | alu_b};
      ALU_XOR:   alu_wide = {1'b0, alu_a ^ alu_b};
      ALU_PASSB: alu_wide = {1'b0, alu_b};
      default:   alu_wide = '0;
    endcase
  end
  assign alu_out      = alu_wide[DW-1:0];
  assign alu_flags_in = {alu_wide[DW-1], (alu_wide[DW-1:0] == '0), alu_wide[DW]};

  // Scoreboard
  typedef struct {
    int kind;
    int addr;
    int data;
    int lat;
  } ev_t;

  ev_t exq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_pc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_ev(input int kind, input int addr, input int data, input int lat);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.lat = lat;
    exq.push_back(e);
  endtask

  task automatic e_rf(input int a, input int d);  push_ev(EV_RF, a, d, 0); endtask
  task automatic e_dm(input int a, input int d);  push_ev(EV_DM, a, d, 0); endtask
  task automatic e_pc(input int p, input int l);  push_ev(EV_PC, 0, p, l); endtask
  task automatic e_ill();                         push_ev(EV_ILL, 0, 0, 0); endtask

  task automatic expect_ev(input int kind, input int addr, input int data);
    ev_t e;
    checks++;
    if (exq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d addr=%0h data=%0h cyc=%0d", kind, addr, data, cyc);
      return;
    end
    e = exq.pop_front();
    if (e.kind != kind || e.addr != addr || e.data != data) begin
      errors++;
      $display("FAIL event got kind=%0d addr=%0h data=%0h, want kind=%0d addr=%0h data=%0h",
               kind, addr, data, e.kind, e.addr, e.data);
    end
    if (kind == EV_PC && e.lat != 0) begin
      checks++;
      if (cyc - last_pc != e.lat) begin
        errors++;
        $display("FAIL latency pc=%0h got=%0d want=%0d", data, cyc - last_pc, e.lat);
      end
    end
  endtask

  always @(negedge clk) begin
    if (illegal_op) expect_ev(EV_ILL, 0, 0);
    if (rf_we)      expect_ev(EV_RF, int'(rf_waddr), int'(rf_wdata));
    if (dmem_we)    expect_ev(EV_DM, int'(dmem_addr), int'(dmem_din));
    if (pc_en) begin
      expect_ev(EV_PC, 0, int'(pc_next));
      last_pc = cyc;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exq.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d", exq.size());
      exq.delete();
    end
    #1;
  endtask

  task automatic step_pulse();
    step = 1'b1;
    @(posedge clk);
    #1;
    step = 1'b0;
  endtask

  task automatic set_pc(input int p);
    pc_set     = 1'b1;
    pc_set_val = DW'(p);
    @(posedge clk);
    #1;
    pc_set = 1'b0;
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; run = 1'b0; step = 1'b0; pc_set = 1'b1; pc_set_val = '0;
    for (int i = 0; i < 512; i++) imem[i] = 16'h0000;
    imem[0]     = 16'hD105; imem[1]     = 16'hD203; imem[2]     = 16'h0251;
    imem[3]     = 16'hD380; imem[4]     = 16'hD400; imem[5]     = 16'h9401;
    imem[6]     = 16'h01B1; imem[7]     = 16'hC003; imem[10]    = 16'hC1FE;
    imem[11]    = 16'hC0FE; imem[9]     = 16'hCE04; imem[13]    = 16'hC202;
    imem[15]    = 16'hD220; imem[16]    = 16'h4241; imem[17]    = 16'h4502;
    imem[18]    = 16'h0F70; imem[19]    = 16'hD640; imem[20]    = 16'h4786;
    imem[9'h40] = 16'h0F00; imem[9'h41] = 16'h41C3; imem[9'h42] = 16'h0133;
    imem[9'h43] = 16'h0112; imem[9'h44] = 16'h0123; imem[9'h45] = 16'h08D4;
    imem[9'h46] = 16'h5801; imem[9'h47] = 16'hB380; imem[9'h48] = 16'h43C3;
    imem[9'h80] = 16'h4686;
    imem[9'h100] = 16'hD911; imem[9'h101] = 16'hDA22; imem[9'h102] = 16'hB911;
    imem[9'h103] = 16'h4249;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'(state_out), 0);
    chk("reset_ir", int'(ir_out), 0);
    chk("reset_psr", int'(psr_out), 0);
    chk("reset_pc_en", int'(pc_en), 0);
    chk("reset_rf_we", int'(rf_we), 0);
    pc_set = 1'b0;
    rst_n  = 1'b1;

    // MOVI/ADD/SUBI sequence, free-running
    e_rf(1, 16'h0005); e_pc(1, 0);
    e_rf(2, 16'h0003); e_pc(2, 4);
    e_rf(2, 16'h0008); e_pc(3, 4);
    e_rf(3, 16'h0080); e_pc(4, 4);
    e_rf(4, 16'h0000); e_pc(5, 4);
    e_rf(4, 16'hFFFF); e_pc(6, 4);
    run = 1'b1;
    drain(200);
    run = 1'b0;
    chk("psr_after_subi", int'(psr_out), 3'b100);
    repeat (4) @(posedge clk);
    #1;
    chk("halted_state", int'(state_out), 0);
    chk("halted_pc", int'(pc), 6);

    // Branches, memory, illegal, JAL, Jcond, logic ops, immediates
    e_pc(7, 0);
    e_pc(10, 3);
    e_pc(11, 3);
    e_pc(9, 3);
    e_pc(13, 3);
    e_pc(15, 3);
    e_rf(2, 16'h0020);  e_pc(16, 4);
    e_dm(9'h020, 5);    e_pc(17, 4);
    e_rf(5, 16'h0005);  e_pc(18, 5);
    e_ill();            e_pc(19, 2);
    e_rf(6, 16'h0040);  e_pc(20, 4);
    e_rf(7, 16'h0015);  e_pc(16'h40, 3);
    e_pc(16'h41, 2);
    e_pc(16'h42, 3);
    e_rf(1, 16'h0085);  e_pc(16'h43, 4);
    e_rf(1, 16'h0000);  e_pc(16'h44, 4);
    e_rf(1, 16'h0080);  e_pc(16'h45, 4);
    e_rf(8, 16'hFFFF);  e_pc(16'h46, 4);
    e_rf(8, 16'h0000);  e_pc(16'h47, 4);
    e_pc(16'h48, 3);
    e_pc(16'h80, 3);
    e_rf(6, 16'h0081);  e_pc(16'h40, 3);
    run = 1'b1;
    drain(600);
    run = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("psr_after_cmpi", int'(psr_out), 3'b000);
    chk("ir_after_jal", int'(ir_out), 16'h4686);
    chk("pc_after_jal", int'(pc), 16'h40);

    // Single-step: one instruction per step pulse
    set_pc(16'h100);
    e_rf(9, 16'h0011); e_pc(16'h101, 0);
    step_pulse();
    drain(50);
    repeat (6) @(posedge clk);
    #1;
    chk("step1_state", int'(state_out), 0);
    chk("step1_pc", int'(pc), 16'h101);
    e_rf(10, 16'h0022); e_pc(16'h102, 0);
    step_pulse();
    drain(50);
    repeat (6) @(posedge clk);
    #1;
    chk("step2_pc", int'(pc), 16'h102);
    e_pc(16'h103, 0);
    step_pulse();
    drain(50);
    #1;
    chk("psr_after_cmpi_step", int'(psr_out), 3'b011);

    // Reset during S_MEM of a STORE must abort it
    step_pulse();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (state_out == S_MEM) found = 1'b1;
    end
    chk("reached_mem", int'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_dmem_we", int'(dmem_we), 0);
    chk("abort_dmem_en", int'(dmem_en), 0);
    chk("abort_pc_en", int'(pc_en), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_state", int'(state_out), 0);
    chk("abort_psr", int'(psr_out), 0);
    chk("abort_ir", int'(ir_out), 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_pc_kept", int'(pc), 16'h103);
    chk("abort_mem_kept", int'(dmem[9'h020]), 5);
    chk("idle_state", int'(state_out), 0);
    chk("queue_empty", exq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
